// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
// Bundles the request/grant handshake between the cores, the shared memory
// port and the four-way round-robin arbiter.
//   req         : per-core request level (cores 0..3)
//   mem_done    : one-cycle completion from the memory side
//   sel         : 2-bit select for the shared 4:1 address/data mux
//   grant       : one-hot grant, or all zero
//   mem_req     : transaction valid toward memory
//   ack         : one-hot, one-cycle completion pulse to the granted core
//   timeout_err : one-cycle pulse alongside ack when release was forced
// Modports: slave = arbiter side, master = requester/memory side.
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if;
    logic [3:0] req;
    logic       mem_done;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       mem_req;
    logic [3:0] ack;
    logic       timeout_err;

    modport slave (
        input  req,
        input  mem_done,
        output sel,
        output grant,
        output mem_req,
        output ack,
        output timeout_err
    );

    modport master (
        output req,
        output mem_done,
        input  sel,
        input  grant,
        input  mem_req,
        input  ack,
        input  timeout_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Four-requester round-robin arbiter in front of one shared L2/memory port.
// Grants one core at a time, drives the shared mux select, and holds the grant
// until the memory side completes or the TIMEOUT cycle budget runs out.
// Ports:
//   clk   : single rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mem_bus_arbiter_if.slave (req, mem_done in; sel, grant, mem_req,
//           ack, timeout_err out; all outputs are registered)
// Parameters:
//   TIMEOUT   : max cycles in BUSY before forced release (1..65535)
//   CNT_WIDTH : timeout counter width, 2**CNT_WIDTH > TIMEOUT
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_bus_arbiter_if.slave   bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    // Counter value on the last permitted BUSY cycle; cnt starts at 0 on the
    // first BUSY cycle, so mem_req stays high for exactly TIMEOUT cycles.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    logic [0:0]           state_q, state_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           sel_q, sel_d;
    logic [3:0]           grant_q, grant_d;
    logic                 mem_req_q, mem_req_d;
    logic [3:0]           ack_q, ack_d;
    logic                 timeout_err_q, timeout_err_d;

    logic [1:0]           win_s;
    logic [1:0]           idx_s;
    logic                 found_s;

    // Round-robin winner: first set request scanning ptr, ptr+1, ptr+2, ptr+3.
    always_comb begin
        win_s   = ptr_q;
        idx_s   = ptr_q;
        found_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx_s = ptr_q + 2'(i);
            if (!found_s && bus.req[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and output computation for the IDLE/BUSY controller.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        sel_d         = sel_q;
        grant_d       = grant_q;
        mem_req_d     = mem_req_q;
        ack_d         = 4'b0000;
        timeout_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req != 4'b0000) begin
                    sel_d     = win_s;
                    grant_d   = 4'b0001 << win_s;
                    mem_req_d = 1'b1;
                    cnt_d     = CNT_ZERO;
                    ptr_d     = win_s + 2'd1;
                    state_d   = ST_BUSY;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CNT_ONE;
                // mem_done has priority, so a completion on the timeout cycle
                // is reported as a normal completion.
                if (bus.mem_done) begin
                    ack_d     = 4'b0001 << sel_q;
                    grant_d   = 4'b0000;
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    ack_d         = 4'b0001 << sel_q;
                    timeout_err_d = 1'b1;
                    grant_d       = 4'b0000;
                    mem_req_d     = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                grant_d   = 4'b0000;
                mem_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= 2'd0;
            cnt_q         <= CNT_ZERO;
            sel_q         <= 2'd0;
            grant_q       <= 4'b0000;
            mem_req_q     <= 1'b0;
            ack_q         <= 4'b0000;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            grant_q       <= grant_d;
            mem_req_q     <= mem_req_d;
            ack_q         <= ack_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.grant       = grant_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.ack         = ack_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter (TIMEOUT=4). Outputs are compared as one
// packed word {sel[1:0], grant[3:0], mem_req, ack[3:0], timeout_err}, sampled
// 1 time unit after each rising edge; inputs are also changed there.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   check_cnt;

    mem_bus_arbiter_if bus_if ();

    mem_bus_arbiter #(
        .TIMEOUT   (4),
        .CNT_WIDTH (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    logic [11:0] obs_s;
    assign obs_s = {bus_if.sel, bus_if.grant, bus_if.mem_req, bus_if.ack, bus_if.timeout_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus_if.req      = 4'b1111;
        bus_if.mem_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_cnt++;
            if (obs_s !== 12'b00_0000_0_0000_0)
                $display("FAIL reset_hold[%0d]: got %b want %b", i, obs_s, 12'b00_0000_0_0000_0);
            else
                pass_cnt++;
        end
        rst_n = 1'b1;
        tick();
        check_cnt++;
        if (obs_s !== 12'b00_0001_1_0000_0)
            $display("FAIL reset_first_grant: got %b want %b", obs_s, 12'b00_0001_1_0000_0);
        else
            pass_cnt++;
    endtask

    // Core 0 is granted on entry; rotate through 1,2,3 and wrap back to 0.
    task automatic test_round_robin();
        logic [1:0]  s;
        logic [1:0]  n;
        logic [11:0] exp_v;
        for (int k = 0; k < 4; k++) begin
            s = 2'(k);
            n = s + 2'd1;
            tick();
            bus_if.mem_done = 1'b1;
            tick();
            bus_if.mem_done = 1'b0;
            exp_v = {s, 4'b0000, 1'b0, 4'b0001 << s, 1'b0};
            check_cnt++;
            if (obs_s !== exp_v)
                $display("FAIL rr_ack[%0d]: got %b want %b", k, obs_s, exp_v);
            else
                pass_cnt++;
            tick();
            exp_v = {n, 4'b0001 << n, 1'b1, 4'b0000, 1'b0};
            check_cnt++;
            if (obs_s !== exp_v)
                $display("FAIL rr_grant[%0d]: got %b want %b", k, obs_s, exp_v);
            else
                pass_cnt++;
        end
    endtask

    // Core 0 granted, ptr=1 on entry.
    task automatic test_pointer_skip();
        tick();
        bus_if.mem_done = 1'b1;
        tick();
        bus_if.mem_done = 1'b0;
        tick();
        check_cnt++;
        if (obs_s !== 12'b01_0010_1_0000_0)
            $display("FAIL skip_grant1: got %b want %b", obs_s, 12'b01_0010_1_0000_0);
        else
            pass_cnt++;
        tick();
        bus_if.mem_done = 1'b1;
        tick();
        bus_if.mem_done = 1'b0;
        check_cnt++;
        if (obs_s !== 12'b01_0000_0_0010_0)
            $display("FAIL skip_ack1: got %b want %b", obs_s, 12'b01_0000_0_0010_0);
        else
            pass_cnt++;
        bus_if.req = 4'b0001;
        tick();
        check_cnt++;
        if (obs_s !== 12'b00_0001_1_0000_0)
            $display("FAIL skip_grant0: got %b want %b", obs_s, 12'b00_0001_1_0000_0);
        else
            pass_cnt++;
        tick();
        bus_if.mem_done = 1'b1;
        tick();
        bus_if.mem_done = 1'b0;
        bus_if.req      = 4'b1001;
        tick();
        check_cnt++;
        if (obs_s !== 12'b11_1000_1_0000_0)
            $display("FAIL skip_grant3: got %b want %b", obs_s, 12'b11_1000_1_0000_0);
        else
            pass_cnt++;
    endtask

    // Core 3 granted, ptr=0 on entry.
    task automatic test_timeout();
        tick();
        bus_if.mem_done = 1'b1;
        tick();
        bus_if.mem_done = 1'b0;
        check_cnt++;
        if (obs_s !== 12'b11_0000_0_1000_0)
            $display("FAIL to_prev_ack: got %b want %b", obs_s, 12'b11_0000_0_1000_0);
        else
            pass_cnt++;
        bus_if.req = 4'b0100;
        tick();
        check_cnt++;
        if (obs_s !== 12'b10_0100_1_0000_0)
            $display("FAIL to_grant2: got %b want %b", obs_s, 12'b10_0100_1_0000_0);
        else
            pass_cnt++;
        bus_if.req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_cnt++;
            if (obs_s !== 12'b10_0100_1_0000_0)
                $display("FAIL to_busy[%0d]: got %b want %b", i, obs_s, 12'b10_0100_1_0000_0);
            else
                pass_cnt++;
        end
        tick();
        check_cnt++;
        if (obs_s !== 12'b10_0000_0_0100_1)
            $display("FAIL to_release: got %b want %b", obs_s, 12'b10_0000_0_0100_1);
        else
            pass_cnt++;
        tick();
        check_cnt++;
        if (obs_s !== 12'b10_0000_0_0000_0)
            $display("FAIL to_pulse_end: got %b want %b", obs_s, 12'b10_0000_0_0000_0);
        else
            pass_cnt++;
    endtask

    // Idle with sel=2, ptr=3 on entry.
    task automatic test_simultaneous();
        bus_if.req = 4'b0001;
        tick();
        check_cnt++;
        if (obs_s !== 12'b00_0001_1_0000_0)
            $display("FAIL sim_grant0: got %b want %b", obs_s, 12'b00_0001_1_0000_0);
        else
            pass_cnt++;
        bus_if.req = 4'b0000;
        tick();
        tick();
        tick();
        bus_if.mem_done = 1'b1;
        tick();
        bus_if.mem_done = 1'b0;
        check_cnt++;
        if (obs_s !== 12'b00_0000_0_0001_0)
            $display("FAIL sim_done_wins: got %b want %b", obs_s, 12'b00_0000_0_0001_0);
        else
            pass_cnt++;
        bus_if.mem_done = 1'b1;
        tick();
        bus_if.mem_done = 1'b0;
        check_cnt++;
        if (obs_s !== 12'b00_0000_0_0000_0)
            $display("FAIL sim_idle_done: got %b want %b", obs_s, 12'b00_0000_0_0000_0);
        else
            pass_cnt++;
        bus_if.req = 4'b0010;
        tick();
        check_cnt++;
        if (obs_s !== 12'b01_0010_1_0000_0)
            $display("FAIL sim_grant1: got %b want %b", obs_s, 12'b01_0010_1_0000_0);
        else
            pass_cnt++;
        bus_if.req = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_cnt++;
            if (obs_s !== 12'b01_0010_1_0000_0)
                $display("FAIL sim_drop_hold[%0d]: got %b want %b", i, obs_s, 12'b01_0010_1_0000_0);
            else
                pass_cnt++;
        end
        bus_if.mem_done = 1'b1;
        tick();
        bus_if.mem_done = 1'b0;
        check_cnt++;
        if (obs_s !== 12'b01_0000_0_0010_0)
            $display("FAIL sim_drop_ack: got %b want %b", obs_s, 12'b01_0000_0_0010_0);
        else
            pass_cnt++;
    endtask

    // Idle, ptr=2 on entry.
    task automatic test_reset_mid_busy();
        bus_if.req = 4'b1000;
        tick();
        check_cnt++;
        if (obs_s !== 12'b11_1000_1_0000_0)
            $display("FAIL rmb_grant3: got %b want %b", obs_s, 12'b11_1000_1_0000_0);
        else
            pass_cnt++;
        tick();
        rst_n           = 1'b0;
        bus_if.mem_done = 1'b1;
        tick();
        bus_if.mem_done = 1'b0;
        check_cnt++;
        if (obs_s !== 12'b00_0000_0_0000_0)
            $display("FAIL rmb_reset_outs: got %b want %b", obs_s, 12'b00_0000_0_0000_0);
        else
            pass_cnt++;
        rst_n = 1'b1;
        tick();
        check_cnt++;
        if (obs_s !== 12'b11_1000_1_0000_0)
            $display("FAIL rmb_regrant3: got %b want %b", obs_s, 12'b11_1000_1_0000_0);
        else
            pass_cnt++;
        bus_if.req      = 4'b1111;
        bus_if.mem_done = 1'b1;
        tick();
        bus_if.mem_done = 1'b0;
        check_cnt++;
        if (obs_s !== 12'b11_0000_0_1000_0)
            $display("FAIL rmb_ack3: got %b want %b", obs_s, 12'b11_0000_0_1000_0);
        else
            pass_cnt++;
        tick();
        check_cnt++;
        if (obs_s !== 12'b00_0001_1_0000_0)
            $display("FAIL rmb_next_grant0: got %b want %b", obs_s, 12'b00_0001_1_0000_0);
        else
            pass_cnt++;
        bus_if.req = 4'b0000;
    endtask

    initial begin
        pass_cnt        = 0;
        check_cnt       = 0;
        rst_n           = 1'b0;
        bus_if.req      = 4'b0000;
        bus_if.mem_done = 1'b0;
        test_reset();
        test_round_robin();
        test_pointer_skip();
        test_timeout();
        test_simultaneous();
        test_reset_mid_busy();
        tick();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Four-requester round-robin arbiter for the shared memory-side bus in the multicore hierarchy. It accepts per-core requests, grants exactly one at a time, and drives the 2-bit select of the shared 4:1 data/address mux. It holds the grant until the memory side signals completion or a timeout expires. One arbiter instance sits in front of each shared L2/memory port.

## Interface
- `TIMEOUT`, default 255: maximum number of cycles in BUSY before the grant is forcibly released. Legal range 1..65535.
- `CNT_WIDTH`, default 16: width of the timeout counter. Must satisfy 2^CNT_WIDTH > TIMEOUT.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  4  request from cores 0..3. Level signal; the core holds it until it sees `ack`.
- `mem_done`  in  1  one-cycle completion from the memory side for the current transaction.
- `sel`  out  2  select for the shared 4:1 mux; encodes the granted requester index.
- `grant`  out  4  one-hot grant, or all zero.
- `mem_req`  out  1  transaction valid toward memory; high throughout BUSY.
- `ack`  out  4  one-hot, one-cycle completion pulse to the granted requester.
- `timeout_err`  out  1  one-cycle pulse, coincident with `ack`, when release was caused by timeout.

## Operation
- Reset (`rst_n`=0 at a clock edge) sets the following; any in-flight transaction is abandoned and no `ack` is issued for it:
  - `sel`=0, `grant`=0, `mem_req`=0, `ack`=0, `timeout_err`=0.
  - Round-robin pointer `ptr`=0, counter=0, state=IDLE.
- State IDLE:
  - If `req`≠0, select the winner by scanning `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4); the first set bit wins.
  - Register `sel`=winner, set `grant` to the winner's one-hot, set `mem_req`=1, clear the counter, and set `ptr`=(winner+1) mod 4 (3 wraps to 0). Go to BUSY.
  - If `req`=0, stay in IDLE; outputs are unchanged except `ack` and `timeout_err`, which are 0.
- State BUSY:
  - The counter increments by 1 each cycle.
  - If `mem_done`=1: pulse `ack[sel]`=1, clear `grant` and `mem_req`, go to IDLE.
  - Else if the counter equals TIMEOUT−1: pulse `ack[sel]`=1 and `timeout_err`=1, clear `grant` and `mem_req`, go to IDLE.
  - If `mem_done` and the timeout occur in the same cycle, `mem_done` wins and `timeout_err` stays 0.
  - Changes on `req` are ignored during BUSY, including the granted core dropping its request. The grant is committed until completion or timeout.
- `sel` changes only at a new grant. It holds its last value while idle so the mux output stays stable.
- `mem_done` in IDLE is ignored.
- Invariants: at most one bit of `grant` and of `ack` is set; `mem_req` equals OR(`grant`).

## Timing
- Request latency:
  - `req` sampled high at edge N (IDLE) gives `grant`, `sel`, and `mem_req` valid after edge N.
  - Memory sees `mem_req` in cycle N+1.
- Completion:
  - `mem_done` sampled at edge M gives `ack` and `timeout_err` high for exactly cycle M+1; `grant` and `mem_req` go low in cycle M+1.
  - The arbiter is in IDLE during cycle M+1. The next grant registers at edge M+1, so it is visible in cycle M+2.
- Minimum turnaround between consecutive grants: 2 cycles from the `mem_done` sample to the next `mem_req`.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles, then `ack` and `timeout_err` pulse in the following cycle.
- A requester that keeps `req` high after its `ack` is re-eligible in cycle M+1. It competes at the lowest priority because `ptr` has advanced past it.

## Test plan
- Reset check:
  - Hold `rst_n`=0 for 3 cycles with `req`=4'b1111 → all outputs stay 0.
  - Release reset → core 0 is granted first (`grant`=0001, `sel`=0).
- Round-robin rotation:
  - `req`=4'b1111 held; `mem_done` pulses 2 cycles after each `mem_req` rise.
  - Required grant sequence: 0001, 0010, 0100, 1000, 0001 (wrap), with `ack` matching each.
- Pointer skip:
  - After core 1 completes, present `req`=4'b0001 → `grant`=0001 and `sel`=0.
  - Then present `req`=4'b1001 → `grant`=1000 (ptr=1 scans 1, 2, 3).
- Timeout:
  - Set TIMEOUT=4; grant core 2; no `mem_done` → `mem_req` is high for 4 cycles.
  - Then `ack`=0100 and `timeout_err`=1 for one cycle; `sel` remains 2.
- Simultaneous events:
  - `mem_done` arrives on the timeout cycle → `ack` pulses and `timeout_err`=0.
  - The granted core drops `req` mid-BUSY → `grant` holds until `mem_done`.
- Reset mid-BUSY:
  - Assert `rst_n`=0 while core 3 is granted → the next cycle shows all outputs 0 and no `ack`.
  - After release with `req`=4'b1000 → `grant`=1000 (ptr restarted at 0).
